wb_bram_ctrl: RTL and testbench

//  Wishbone B4 classic slave that fronts the byte-addressed, word-wide user-project BRAM.
//  It decodes an address window and issues single-cycle EN0/WE0 accesses to the BRAM port
//  (BRAM Do0: 1-cycle registered read latency, forced to 0 when EN0 is low).
//  It captures read data and returns a one-cycle ack to the Caravel management-core Wishbone bus.

---
 rtl/wb_bram_ctrl_if.sv | 50 +++++
 rtl/wb_bram_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_wb_bram_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_ctrl_if
// Description : Wishbone B4 classic slave-side signal bundle used between the
//               Caravel management-core bus and wb_bram_ctrl.
//               Signal names keep the Caravel wbs_* naming so the bundle maps
//               one-to-one onto the user-project wrapper.
//   wbs_cyc_i  : bus cycle valid          (master -> slave)
//   wbs_stb_i  : strobe                   (master -> slave)
//   wbs_we_i   : 1 = write, 0 = read      (master -> slave)
//   wbs_sel_i  : byte lane select [3:0]   (master -> slave)
//   wbs_adr_i  : byte address [31:0]      (master -> slave)
//   wbs_dat_i  : write data [31:0]        (master -> slave)
//   wbs_ack_o  : one-cycle transfer ack   (slave -> master)
//   wbs_dat_o  : read data [31:0]         (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_bram_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_ctrl
// Description : Wishbone B4 classic slave fronting a byte-addressed, word-wide
//               single-port BRAM (1-cycle registered read, Do0 = 0 when EN0
//               is low). A hit inside the address window launches exactly one
//               EN0 cycle, the read data is captured one cycle later, and a
//               single-cycle ack is returned (optionally after EXTRA_WAIT
//               extra cycles). All outputs are registered.
// Ports       :
//   CLK        in   1   clock, all logic on posedge
//   RST_N      in   1   asynchronous active-low reset
//   wb         --  --   Wishbone slave bundle (wb_bram_ctrl_if.slave)
//   bram_EN0   out  1   BRAM enable
//   bram_WE0   out  4   BRAM byte write enables
//   bram_A0    out  32  BRAM byte address (BRAM decodes [31:2])
//   bram_Di0   out  32  BRAM write data
//   bram_Do0   in   32  BRAM read data
// Parameters  :
//   ADDR_BASE  window base; hit when (adr & ADDR_MASK) == ADDR_BASE
//   ADDR_MASK  window mask; BRAM byte offset = adr & ~ADDR_MASK
//   EXTRA_WAIT extra wait cycles before ack (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bram_ctrl #(
    parameter logic [31:0] ADDR_BASE  = 32'h3800_0000,
    parameter logic [31:0] ADDR_MASK  = 32'hFFC0_0000,
    parameter int unsigned EXTRA_WAIT = 0
) (
    input  wire logic        CLK,
    input  wire logic        RST_N,
    wb_bram_ctrl_if.slave    wb,
    output logic             bram_EN0,
    output logic [3:0]       bram_WE0,
    output logic [31:0]      bram_A0,
    output logic [31:0]      bram_Di0,
    input  wire logic [31:0] bram_Do0
);

    // Value loaded into the wait counter on leaving CAPTURE; the counter
    // then reaches zero after EXTRA_WAIT-1 decrements so ACK is entered
    // exactly EXTRA_WAIT cycles later than with no wait.
    localparam logic [3:0] c_WAIT_LOAD = (EXTRA_WAIT > 0) ? 4'(EXTRA_WAIT - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_WAIT    = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;      // latched direction of the request in flight
    logic        r_ack;
    logic [31:0] r_dat_o;
    logic        r_en0;
    logic [3:0]  r_we0;
    logic [31:0] r_a0;
    logic [31:0] r_di0;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_wr_nxt;
    logic        w_ack_nxt;
    logic [31:0] w_dat_o_nxt;
    logic        w_en0_nxt;
    logic [3:0]  w_we0_nxt;
    logic [31:0] w_a0_nxt;
    logic [31:0] w_di0_nxt;

    logic        w_hit;

    assign w_hit = wb.wbs_cyc_i && wb.wbs_stb_i &&
                   ((wb.wbs_adr_i & ADDR_MASK) == ADDR_BASE);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_ack   <= 1'b0;
            r_dat_o <= 32'd0;
            r_en0   <= 1'b0;
            r_we0   <= 4'd0;
            r_a0    <= 32'd0;
            r_di0   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr    <= w_wr_nxt;
            r_ack   <= w_ack_nxt;
            r_dat_o <= w_dat_o_nxt;
            r_en0   <= w_en0_nxt;
            r_we0   <= w_we0_nxt;
            r_a0    <= w_a0_nxt;
            r_di0   <= w_di0_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // EN0, WE0 and ack default low so each is high for exactly one cycle;
    // A0/Di0 hold their last request and dat_o holds until the next capture.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_nxt    = r_wr;
        w_ack_nxt   = 1'b0;
        w_dat_o_nxt = r_dat_o;
        w_en0_nxt   = 1'b0;
        w_we0_nxt   = 4'd0;
        w_a0_nxt    = r_a0;
        w_di0_nxt   = r_di0;

        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = S_ISSUE;
                    w_en0_nxt   = 1'b1;
                    w_a0_nxt    = wb.wbs_adr_i & ~ADDR_MASK;
                    w_di0_nxt   = wb.wbs_dat_i;
                    w_we0_nxt   = wb.wbs_we_i ? wb.wbs_sel_i : 4'd0;
                    w_wr_nxt    = wb.wbs_we_i;
                end
            end

            // The BRAM samples EN0/WE0 at the edge leaving this state, so
            // the access completes even if the master has dropped cyc.
            S_ISSUE: begin
                w_state_nxt = wb.wbs_cyc_i ? S_CAPTURE : S_IDLE;
            end

            // bram_Do0 is valid now. An aborted cycle leaves dat_o alone.
            S_CAPTURE: begin
                if (!wb.wbs_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_dat_o_nxt = r_wr ? 32'd0 : bram_Do0;
                    if (EXTRA_WAIT == 0) begin
                        w_state_nxt = S_ACK;
                        w_ack_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WAIT_LOAD;
                    end
                end
            end

            S_WAIT: begin
                if (!wb.wbs_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                    w_ack_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end

            // Ack is already high for this cycle; stb is not re-sampled
            // until IDLE, which forces one idle cycle between transfers.
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat_o;
    assign bram_EN0     = r_en0;
    assign bram_WE0     = r_we0;
    assign bram_A0      = r_a0;
    assign bram_Di0     = r_di0;

endmodule
`default_nettype wire

// File: tb/tb_wb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bram_ctrl
// Description : Self-checking bench for wb_bram_ctrl. Two instances: one with
//               EXTRA_WAIT=0, one with EXTRA_WAIT=3, each backed by a
//               behavioural BRAM (1-cycle registered read, Do0=0 when EN0 low).
//               Table-driven transfers plus hand-written reset/abort/wait
//               sequences; read data is checked through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bram_ctrl;

    localparam logic [31:0] c_MASK = 32'hFFC0_0000;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic r_clr = 1'b1;

    always #5 CLK = ~CLK;

    wb_bram_ctrl_if u_if1 ();
    wb_bram_ctrl_if u_if2 ();

    logic        w_en1, w_en2;
    logic [3:0]  w_we1, w_we2;
    logic [31:0] w_a1, w_a2, w_di1, w_di2;
    logic [31:0] r_do1, r_do2;

    wb_bram_ctrl #(.EXTRA_WAIT(0)) u_dut1 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wb       (u_if1),
        .bram_EN0 (w_en1),
        .bram_WE0 (w_we1),
        .bram_A0  (w_a1),
        .bram_Di0 (w_di1),
        .bram_Do0 (r_do1)
    );

    wb_bram_ctrl #(.EXTRA_WAIT(3)) u_dut2 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wb       (u_if2),
        .bram_EN0 (w_en2),
        .bram_WE0 (w_we2),
        .bram_A0  (w_a2),
        .bram_Di0 (w_di2),
        .bram_Do0 (r_do2)
    );

    // ------------------------------------------------------------------
    // Behavioural BRAMs (256 words, word index = A0[9:2])
    // ------------------------------------------------------------------
    logic [31:0] r_mem1 [0:255];
    logic [31:0] r_mem2 [0:255];

    always @(posedge CLK) begin
        if (r_clr) begin
            for (int i = 0; i < 256; i++) r_mem1[i] <= 32'h0;
            r_do1 <= 32'h0;
        end else if (w_en1) begin
            for (int b = 0; b < 4; b++)
                if (w_we1[b]) r_mem1[w_a1[9:2]][8*b +: 8] <= w_di1[8*b +: 8];
            r_do1 <= r_mem1[w_a1[9:2]];
        end else begin
            r_do1 <= 32'h0;
        end
    end

    always @(posedge CLK) begin
        if (r_clr) begin
            for (int i = 0; i < 256; i++) r_mem2[i] <= 32'h0;
            r_do2 <= 32'h0;
        end else if (w_en2) begin
            for (int b = 0; b < 4; b++)
                if (w_we2[b]) r_mem2[w_a2[9:2]][8*b +: 8] <= w_di2[8*b +: 8];
            r_do2 <= r_mem2[w_a2[9:2]];
        end else begin
            r_do2 <= 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // EN0 monitors: running pulse counts and the request seen while EN0=1
    // ------------------------------------------------------------------
    int          en_total1 = 0, en_total2 = 0;
    logic [3:0]  cap_we1, cap_we2;
    logic [31:0] cap_a1, cap_a2, cap_di1, cap_di2;

    always @(negedge CLK) begin
        if (w_en1) begin
            en_total1 = en_total1 + 1;
            cap_we1 = w_we1; cap_a1 = w_a1; cap_di1 = w_di1;
        end
        if (w_en2) begin
            en_total2 = en_total2 + 1;
            cap_we2 = w_we2; cap_a2 = w_a2; cap_di2 = w_di2;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q [$];
    logic [31:0] last_dat1 = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input int d);
        return (d == 1) ? u_if1.wbs_ack_o : u_if2.wbs_ack_o;
    endfunction

    function automatic logic [31:0] dato_of(input int d);
        return (d == 1) ? u_if1.wbs_dat_o : u_if2.wbs_dat_o;
    endfunction

    task automatic drive(input int d, input logic act, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        if (d == 1) begin
            u_if1.wbs_cyc_i = act; u_if1.wbs_stb_i = act; u_if1.wbs_we_i = we;
            u_if1.wbs_sel_i = sel; u_if1.wbs_adr_i = adr; u_if1.wbs_dat_i = dat;
        end else begin
            u_if2.wbs_cyc_i = act; u_if2.wbs_stb_i = act; u_if2.wbs_we_i = we;
            u_if2.wbs_sel_i = sel; u_if2.wbs_adr_i = adr; u_if2.wbs_dat_i = dat;
        end
    endtask

    // Compare the data returned with an ack against the scoreboard head.
    task automatic sb_pop(input int d, input string tag);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s unexpected ack: got dat %h, expected no ack", tag, dato_of(d));
        end else begin
            exp = sb_q.pop_front();
            chk({tag, " dat_o"}, dato_of(d), exp);
            if (d == 1) last_dat1 = exp;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " ack"},  {31'd0, u_if1.wbs_ack_o}, 32'h0);
        chk({tag, " dat_o"}, u_if1.wbs_dat_o, 32'h0);
        chk({tag, " EN0"},  {31'd0, w_en1}, 32'h0);
        chk({tag, " WE0"},  {28'd0, w_we1}, 32'h0);
        chk({tag, " A0"},   w_a1, 32'h0);
        chk({tag, " Di0"},  w_di1, 32'h0);
    endtask

    // One complete Wishbone transfer on DUT d with full checking.
    task automatic xfer(input int d, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic hit, input logic [31:0] exp_rd, input string tag);
        int          base;
        int          k;
        int          lat;
        logic        acked;
        logic [31:0] off;
        off = adr & ~c_MASK;
        lat = (d == 1) ? 3 : 6;   // sample index of ack: e0 is index 1
        @(negedge CLK);
        base = (d == 1) ? en_total1 : en_total2;
        drive(d, 1'b1, we, sel, adr, dat);
        if (hit) sb_q.push_back(we ? 32'h0 : exp_rd);
        acked = 1'b0;
        k = 0;
        while (!acked && k < 20) begin
            @(posedge CLK);
            k++;
            @(negedge CLK);
            if (ack_of(d)) acked = 1'b1;
        end
        if (acked) sb_pop(d, tag);
        drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk({tag, " ack latency"}, acked ? k : 0, hit ? lat : 0);
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, " ack width"}, {31'd0, ack_of(d)}, 32'h0);
        chk({tag, " EN0 pulses"}, ((d == 1) ? en_total1 : en_total2) - base, hit ? 1 : 0);
        if (hit) begin
            chk({tag, " A0"},  (d == 1) ? cap_a1 : cap_a2, off);
            chk({tag, " WE0"}, {28'd0, (d == 1) ? cap_we1 : cap_we2}, {28'd0, we ? sel : 4'h0});
            chk({tag, " Di0"}, (d == 1) ? cap_di1 : cap_di2, dat);
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table for DUT1
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int base;
        int acks;

        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        //          we    sel   adr            dat            hit   exp_rd
        vecs[0]  = '{1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 4'h4, 32'h3800_0010, 32'h00AA_0000, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         1'b1, 32'hDEAA_BEEF};
        vecs[4]  = '{1'b1, 4'h0, 32'h3800_0010, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         1'b1, 32'hDEAA_BEEF};
        vecs[6]  = '{1'b1, 4'h3, 32'h3800_0020, 32'h1122_3344, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 4'hF, 32'h3800_0020, 32'h0,         1'b1, 32'h0000_3344};
        vecs[8]  = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b1, 4'hF, 32'h383F_FFFC, 32'hA5A5_5A5A, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 4'hF, 32'h383F_FFFC, 32'h0,         1'b1, 32'hA5A5_5A5A};
        vecs[11] = '{1'b1, 4'hF, 32'h3840_0000, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 4'hF, 32'h3800_0000, 32'h0,         1'b1, 32'h0};
        vecs[13] = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         1'b1, 32'hDEAA_BEEF};

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_outputs_zero("reset");
        r_clr = 1'b0;
        RST_N = 1'b1;

        for (int i = 0; i < 14; i++)
            xfer(1, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat,
                 vecs[i].hit, vecs[i].exp_rd, $sformatf("vec%0d", i));

        // Abort: write, cyc dropped during CAPTURE -> no ack, data committed
        @(negedge CLK);
        drive(1, 1'b1, 1'b1, 4'hF, 32'h3800_0030, 32'hCAFE_F00D);
        @(posedge CLK);                 // e0: -> ISSUE
        @(posedge CLK);                 // -> CAPTURE
        @(negedge CLK);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        acks = 0;
        repeat (10) begin
            @(negedge CLK);
            if (u_if1.wbs_ack_o) acks++;
        end
        chk("abort ack count", acks, 0);
        chk("abort dat_o held", u_if1.wbs_dat_o, last_dat1);
        xfer(1, 1'b0, 4'hF, 32'h3800_0030, 32'h0, 1'b1, 32'hCAFE_F00D, "abort readback");

        // Reset asserted mid-read while in CAPTURE
        @(negedge CLK);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h3800_0010, 32'h0);
        @(posedge CLK);                 // e0: -> ISSUE
        @(posedge CLK);                 // -> CAPTURE
        #2 RST_N = 1'b0;
        #1 chk_outputs_zero("midreset");
        @(negedge CLK);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        RST_N = 1'b1;
        base = en_total1;
        acks = 0;
        repeat (10) begin
            @(negedge CLK);
            if (u_if1.wbs_ack_o) acks++;
        end
        chk("midreset ack after release", acks, 0);
        chk("midreset EN0 after release", en_total1 - base, 0);

        // EXTRA_WAIT=3 instance: ack at e0+5 for both write and read
        xfer(2, 1'b1, 4'hF, 32'h3800_0040, 32'h1234_5678, 1'b1, 32'h0, "wait3 write");
        xfer(2, 1'b0, 4'hF, 32'h3800_0040, 32'h0, 1'b1, 32'h1234_5678, "wait3 read");
        xfer(2, 1'b0, 4'hF, 32'h3100_0040, 32'h0, 1'b0, 32'h0, "wait3 miss");

        chk("scoreboard drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
